key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 142 ++++++++++++++
 tb/tb_key_conditioner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounce, press detect and auto-repeat for two pushbuttons
// KEY[0] is submit, KEY[1] is increment; only KEY[1] has an auto-repeat path.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 10_000_000,
  parameter int REPEAT_PERIOD   = 4_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] KEY,
  input  logic       rep_en,
  output logic [1:0] held,
  output logic [1:0] press,
  output logic       inc_pulse
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ABC = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW      = (MAX_ABC > 2) ? $clog2(MAX_ABC) : 1;

  // Reload values floor at 1 so a strobe can never land on the cycle right after
  // a press or another strobe, even with degenerate repeat parameters.
  localparam int RD_LOAD_I = (REPEAT_DELAY > 2) ? REPEAT_DELAY - 1 : 1;
  localparam int RP_LOAD_I = (REPEAT_PERIOD > 2) ? REPEAT_PERIOD - 1 : 1;

  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_LOAD_I);
  localparam logic [CW-1:0] RP_LOAD = CW'(RP_LOAD_I);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    s;
  logic [1:0]    held_q;
  logic [1:0]    held_d;
  logic [1:0]    press_q;
  logic [1:0]    press_d;
  logic [CW-1:0] dcnt_q [2];
  logic [CW-1:0] dcnt_d [2];

  rep_state_e    state_q;
  rep_state_e    state_d;
  logic [CW-1:0] rcnt_q;
  logic [CW-1:0] rcnt_d;
  logic          rep_strobe;

  // Synchronizer resets to 1 so the keys read as released out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  always_comb begin
    held_d = held_q;
    for (int k = 0; k < 2; k++) begin
      dcnt_d[k] = '0;
      if (s[k] != held_q[k]) begin
        if (dcnt_q[k] == DB_MAX) begin
          held_d[k] = s[k];
        end else begin
          dcnt_d[k] = dcnt_q[k] + CNT_ONE;
        end
      end
    end
    press_d = held_d & ~held_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q    <= 2'b00;
      press_q   <= 2'b00;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
    end else begin
      held_q    <= held_d;
      press_q   <= press_d;
      dcnt_q[0] <= dcnt_d[0];
      dcnt_q[1] <= dcnt_d[1];
    end
  end

  // Release or loss of rep_en wins over an expiring counter in the same cycle.
  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    rep_strobe = 1'b0;
    if (!held_q[1] || !rep_en) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_q[1]) begin
            state_d = ST_DELAY;
            rcnt_d  = RD_LOAD;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (rcnt_q == '0) begin
            rep_strobe = 1'b1;
            state_d    = ST_REPEAT;
            rcnt_d     = RP_LOAD;
          end else begin
            rcnt_d = rcnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign held      = held_q;
  assign press     = press_q;
  assign inc_pulse = press_q[1] | rep_strobe;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] KEY = 2'b11;
  logic       rep_en = 1'b0;
  logic [1:0] held;
  logic [1:0] press;
  logic       inc_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .KEY      (KEY),
    .rep_en   (rep_en),
    .held     (held),
    .press    (press),
    .inc_pulse(inc_pulse)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset;
    KEY = 2'b00;
    rep_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({held, press, inc_pulse} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold: got held=%b press=%b inc=%b, want all 0", held, press, inc_pulse);
      end
    end
    KEY = 2'b11;
    rep_en = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({held, press, inc_pulse} !== 5'b0) begin
        errors++;
        $display("FAIL reset_release: got held=%b press=%b inc=%b, want all 0", held, press, inc_pulse);
      end
    end
  endtask

  task automatic test_clean_press;
    rep_en = 1'b1;
    KEY[0] = 1'b0;
    for (int e = 0; e < 25; e++) begin
      tick();
      checks++;
      if (held[0] !== (e >= 5)) begin
        errors++;
        $display("FAIL clean_held0 edge %0d: got %b want %b", e, held[0], (e >= 5));
      end
      checks++;
      if (press !== ((e == 5) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %b", e, press);
      end
      checks++;
      if (inc_pulse !== 1'b0) begin
        errors++;
        $display("FAIL clean_no_inc edge %0d: got %b want 0", e, inc_pulse);
      end
    end
    KEY[0] = 1'b1;
    rep_en = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (press !== 2'b00 || held[0] !== (e < 5)) begin
        errors++;
        $display("FAIL clean_release edge %0d: got press=%b held0=%b want press=00 held0=%b", e, press, held[0], (e < 5));
      end
    end
  endtask

  task automatic test_bounce;
    logic [15:0] pat;
    pat = 16'b1111_1111_1000_1000;
    for (int e = 0; e < 16; e++) begin
      KEY[1] = pat[e];
      tick();
      checks++;
      if (held[1] !== 1'b0 || press !== 2'b00 || inc_pulse !== 1'b0) begin
        errors++;
        $display("FAIL bounce edge %0d: got held1=%b press=%b inc=%b want 0", e, held[1], press, inc_pulse);
      end
    end
    KEY[1] = 1'b1;
  endtask

  task automatic test_hold_repeat;
    logic exp_inc;
    logic exp_held;
    rep_en = 1'b1;
    KEY[1] = 1'b0;
    for (int k = -5; k <= 40; k++) begin
      tick();
      exp_inc  = (k == 0) || (k >= 10 && k < 36 && ((k - 10) % 3) == 0);
      exp_held = (k >= 0) && (k < 36);
      checks++;
      if (inc_pulse !== exp_inc) begin
        errors++;
        $display("FAIL repeat_inc P+%0d: got %b want %b", k, inc_pulse, exp_inc);
      end
      checks++;
      if (held[1] !== exp_held || press[1] !== (k == 0)) begin
        errors++;
        $display("FAIL repeat_held P+%0d: got held1=%b press1=%b want %b %b", k, held[1], press[1], exp_held, (k == 0));
      end
      if (k == 30) KEY[1] = 1'b1;
    end
    rep_en = 1'b0;
    settle();
  endtask

  task automatic test_gating;
    logic exp_inc;
    rep_en = 1'b1;
    KEY[1] = 1'b0;
    for (int k = -5; k <= 35; k++) begin
      tick();
      exp_inc = (k == 0) || (k == 10);
      checks++;
      if (inc_pulse !== exp_inc) begin
        errors++;
        $display("FAIL gating_inc P+%0d: got %b want %b", k, inc_pulse, exp_inc);
      end
      if (k == 11) rep_en = 1'b0;
      if (k == 20) rep_en = 1'b1;
    end
    KEY[1] = 1'b1;
    rep_en = 1'b0;
    settle();
    checks++;
    if (held !== 2'b00) begin
      errors++;
      $display("FAIL gating_release: got held=%b want 00", held);
    end
  endtask

  task automatic test_release_expiry;
    logic exp_held;
    rep_en = 1'b1;
    KEY[1] = 1'b0;
    for (int k = -5; k <= 25; k++) begin
      tick();
      exp_held = (k >= 0) && (k < 10);
      checks++;
      if (inc_pulse !== (k == 0)) begin
        errors++;
        $display("FAIL expiry_inc P+%0d: got %b want %b", k, inc_pulse, (k == 0));
      end
      checks++;
      if (held[1] !== exp_held) begin
        errors++;
        $display("FAIL expiry_held P+%0d: got %b want %b", k, held[1], exp_held);
      end
      if (k == 4) KEY[1] = 1'b1;
    end
    rep_en = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid_repeat;
    rep_en = 1'b1;
    KEY[1] = 1'b0;
    for (int k = -5; k <= 4; k++) begin
      tick();
      if (k == 0) begin
        checks++;
        if (press[1] !== 1'b1) begin
          errors++;
          $display("FAIL rstrep_first_press: got %b want 1", press[1]);
        end
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({held, press, inc_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL rstrep_async: got held=%b press=%b inc=%b want all 0", held, press, inc_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({held, press, inc_pulse} !== 5'b0) begin
        errors++;
        $display("FAIL rstrep_during: got held=%b press=%b inc=%b want all 0", held, press, inc_pulse);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (press[1] !== (n == 6) || inc_pulse !== (n == 6) || held[1] !== (n >= 6)) begin
        errors++;
        $display("FAIL rstrep_after edge %0d: got press1=%b inc=%b held1=%b want %b %b %b",
                 n, press[1], inc_pulse, held[1], (n == 6), (n == 6), (n >= 6));
      end
    end
    KEY[1] = 1'b1;
    rep_en = 1'b0;
    settle();
  endtask

  task automatic test_simultaneous;
    rep_en = 1'b0;
    KEY = 2'b00;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if (press !== ((e == 5) ? 2'b11 : 2'b00) || inc_pulse !== (e == 5)) begin
        errors++;
        $display("FAIL simul_press edge %0d: got press=%b inc=%b", e, press, inc_pulse);
      end
      checks++;
      if (held !== ((e >= 5) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL simul_held edge %0d: got %b", e, held);
      end
    end
    KEY = 2'b11;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (press !== 2'b00 || inc_pulse !== 1'b0 || held !== ((e < 5) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL simul_release edge %0d: got press=%b inc=%b held=%b", e, press, inc_pulse, held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_gating();
    test_release_expiry();
    test_reset_mid_repeat();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
